// File: rtl/var_delay_line_if.sv
// Sample stream bus for the variable delay line: input beat, delay select and flush in;
// delayed sample, its qualifier and the fill count out.
// width is the sample width; DW must equal $clog2(depth+1) of the attached delay line.
interface var_delay_line_if #(
  parameter int width = 1,
  parameter int DW    = 5
);
  logic [width-1:0] in;
  logic             in_valid;
  logic [DW-1:0]    delay;
  logic             flush;
  logic [width-1:0] out;
  logic             out_valid;
  logic [DW-1:0]    fill;

  modport master (
    output in, in_valid, delay, flush,
    input  out, out_valid, fill
  );

  modport slave (
    input  in, in_valid, delay, flush,
    output out, out_valid, fill
  );
endinterface

// File: rtl/var_delay_line.sv
// Runtime-programmable delay of 0..depth accepted beats over a circular buffer.
// Latency: combinational read, a sample accepted at beat t appears at beat t+D (D=0 is a bypass).
// No backpressure: beats advance on in_valid only; stalls freeze pointer, fill and buffer.
module var_delay_line #(
  parameter int  width = 1,
  parameter int  depth = 16,
  localparam int DW    = $clog2(depth + 1)
) (
  input  logic           clk,
  input  logic           rst,
  var_delay_line_if.slave bus
);

  localparam int            AW    = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [DW-1:0] DMAX  = DW'(depth);
  localparam logic [AW-1:0] WLAST = AW'(depth - 1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [DW-1:0]    d_act;
  logic [DW-1:0]    dreq;
  logic [DW-1:0]    fill_q;
  logic             chg;

  // Clamp the requested delay and detect a change against the active one.
  always_comb begin
    dreq = (bus.delay > DMAX) ? DMAX : bus.delay;
    chg  = (dreq != d_act);
  end

  // Read index (wp - d_act) mod depth, done explicitly so non-power-of-2 depths wrap correctly.
  always_comb begin
    int sum;
    sum = int'(wp) + depth - int'(d_act);
    if (sum >= depth) begin
      sum = sum - depth;
    end
    rp = AW'(sum);
  end

  // Write pointer, active delay and saturating fill count; flush/delay change clear fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp     <= '0;
      d_act  <= '0;
      fill_q <= '0;
    end else begin
      if (bus.in_valid) begin
        wp <= (wp == WLAST) ? '0 : wp + 1'b1;
      end
      if (chg) begin
        d_act <= dreq;
      end
      if (bus.flush || chg) begin
        fill_q <= '0;
      end else if (bus.in_valid && (fill_q != DMAX)) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

  // Sample storage; contents are not cleared, the fill count guards stale entries.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      mem[wp] <= bus.in;
    end
  end

  // Output select: bypass at d_act=0, else buffer read gated by fill; forced quiet in reset.
  always_comb begin
    bus.out       = '0;
    bus.out_valid = 1'b0;
    bus.fill      = fill_q;
    if (!rst) begin
      if (d_act == '0) begin
        bus.out       = bus.in;
        bus.out_valid = bus.in_valid && !chg;
      end else if (bus.in_valid && !chg && (fill_q >= d_act)) begin
        bus.out       = mem[rp];
        bus.out_valid = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_var_delay_line.sv
// Scoreboarded bench for var_delay_line: a depth-16 and a depth-5 instance run the same stream.
// The model keeps the full history of accepted samples and predicts each cycle's output.
module tb_var_delay_line;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  var_delay_line_if #(.width(8), .DW(5)) b16();
  var_delay_line_if #(.width(8), .DW(3)) b5();

  var_delay_line #(.width(8), .depth(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
  var_delay_line #(.width(8), .depth(5))  u5  (.clk(clk), .rst(rst), .bus(b5));

  typedef struct {
    logic       v;
    logic [7:0] o;
    int         f;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] hist[$];
  int         m_fill[2];
  int         m_dact[2];
  int         depths[2] = '{16, 5};
  int         checks = 0;
  int         errors = 0;
  logic       last_v16, last_v5;
  logic [7:0] last_o16, last_o5;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fill[k] = 0;
      m_dact[k] = 0;
    end
  endtask

  // One cycle: drive both DUTs, push predictions, compare at the falling edge.
  task automatic step(input logic [7:0] vin, input logic vld, input int dly, input logic fl);
    exp_t e;
    b16.in = vin;        b5.in = vin;
    b16.in_valid = vld;  b5.in_valid = vld;
    b16.flush = fl;      b5.flush = fl;
    b16.delay = 5'((dly > 31) ? 31 : dly);
    b5.delay  = 3'((dly > 7) ? 7 : dly);
    for (int k = 0; k < 2; k++) begin
      int   dd;
      int   dr;
      logic chg;
      dd  = (k == 0) ? ((dly > 31) ? 31 : dly) : ((dly > 7) ? 7 : dly);
      dr  = (dd > depths[k]) ? depths[k] : dd;
      chg = (dr != m_dact[k]);
      e.f = m_fill[k];
      if (m_dact[k] == 0) begin
        e.v = vld && !chg;
        e.o = vin;
      end else begin
        e.v = vld && !chg && (m_fill[k] >= m_dact[k]);
        e.o = e.v ? hist[hist.size() - m_dact[k]] : 8'h00;
      end
      sb.push_back(e);
      if (chg) m_dact[k] = dr;
      if (fl || chg) m_fill[k] = 0;
      else if (vld && (m_fill[k] < depths[k])) m_fill[k] = m_fill[k] + 1;
    end
    if (vld) hist.push_back(vin);
    @(negedge clk);
    last_v16 = b16.out_valid;  last_o16 = b16.out;
    last_v5  = b5.out_valid;   last_o5  = b5.out;
    for (int k = 0; k < 2; k++) begin
      logic       ov;
      logic [7:0] oo;
      int         of;
      e  = sb.pop_front();
      ov = (k == 0) ? b16.out_valid : b5.out_valid;
      oo = (k == 0) ? b16.out : b5.out;
      of = (k == 0) ? int'(b16.fill) : int'(b5.fill);
      checks++;
      if (ov !== e.v) begin
        errors++;
        $display("FAIL sb_out_valid dut%0d t=%0t got %b want %b", depths[k], $time, ov, e.v);
      end
      checks++;
      if (oo !== e.o) begin
        errors++;
        $display("FAIL sb_out dut%0d t=%0t got %0d want %0d", depths[k], $time, oo, e.o);
      end
      checks++;
      if (of != e.f) begin
        errors++;
        $display("FAIL sb_fill dut%0d t=%0t got %0d want %0d", depths[k], $time, of, e.f);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b16.in = 8'h3C;  b5.in = 8'h3C;
    b16.in_valid = 1'b1;  b5.in_valid = 1'b1;
    b16.delay = '0;  b5.delay = '0;
    b16.flush = 1'b0;  b5.flush = 1'b0;
    #1;
    checks++;
    if (b16.out_valid !== 1'b0 || b5.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b/%b want 0/0", b16.out_valid, b5.out_valid);
    end
    checks++;
    if (b16.out !== 8'h00 || b5.out !== 8'h00) begin
      errors++;
      $display("FAIL reset_out got %0h/%0h want 0/0", b16.out, b5.out);
    end
    checks++;
    if (b16.fill !== 5'd0 || b5.fill !== 3'd0) begin
      errors++;
      $display("FAIL reset_fill got %0d/%0d want 0/0", b16.fill, b5.fill);
    end
    b16.in_valid = 1'b0;  b5.in_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_delay3_ramp();
    step(8'd0, 1'b0, 3, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(8'(i), 1'b1, 3, 1'b0);
      if (i <= 3) begin
        checks++;
        if (last_v16 !== 1'b0) begin
          errors++;
          $display("FAIL ramp3_early beat %0d got valid %b want 0", i, last_v16);
        end
      end else if (i == 4 || i == 5) begin
        checks++;
        if (last_v16 !== 1'b1 || last_o16 !== 8'(i - 3)) begin
          errors++;
          $display("FAIL ramp3_out beat %0d got %b/%0d want 1/%0d", i, last_v16, last_o16, i - 3);
        end
      end
    end
  endtask

  task automatic test_bypass();
    step(8'h00, 1'b0, 0, 1'b0);
    step(8'hA5, 1'b1, 0, 1'b0);
    checks++;
    if (last_v16 !== 1'b1 || last_o16 !== 8'hA5) begin
      errors++;
      $display("FAIL bypass_valid got %b/%0h want 1/a5", last_v16, last_o16);
    end
    step(8'h5A, 1'b0, 0, 1'b0);
    checks++;
    if (last_v16 !== 1'b0) begin
      errors++;
      $display("FAIL bypass_idle got valid %b want 0", last_v16);
    end
  endtask

  task automatic test_stall();
    step(8'd0, 1'b0, 3, 1'b0);
    step(8'd10, 1'b1, 3, 1'b0);
    step(8'd77, 1'b0, 3, 1'b0);
    step(8'd88, 1'b0, 3, 1'b0);
    step(8'd11, 1'b1, 3, 1'b0);
    step(8'd12, 1'b1, 3, 1'b0);
    checks++;
    if (last_v16 !== 1'b0) begin
      errors++;
      $display("FAIL stall_early got valid %b want 0", last_v16);
    end
    step(8'd13, 1'b1, 3, 1'b0);
    checks++;
    if (last_v16 !== 1'b1 || last_o16 !== 8'd10) begin
      errors++;
      $display("FAIL stall_align got %b/%0d want 1/10", last_v16, last_o16);
    end
    step(8'd14, 1'b1, 3, 1'b0);
    checks++;
    if (last_o16 !== 8'd11) begin
      errors++;
      $display("FAIL stall_next got %0d want 11", last_o16);
    end
  endtask

  task automatic test_delay_change();
    int nvalid;
    for (int i = 15; i <= 19; i++) step(8'(i), 1'b1, 3, 1'b0);
    step(8'd20, 1'b1, 5, 1'b0);
    checks++;
    if (last_v16 !== 1'b0 || b16.fill !== 5'd0) begin
      errors++;
      $display("FAIL chg_cycle got valid %b fill %0d want 0/0", last_v16, b16.fill);
    end
    nvalid = 0;
    for (int i = 21; i <= 25; i++) begin
      step(8'(i), 1'b1, 5, 1'b0);
      if (last_v16 === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL chg_refill got %0d valid beats want 0", nvalid);
    end
    step(8'd26, 1'b1, 5, 1'b0);
    checks++;
    if (last_v16 !== 1'b1 || last_o16 !== 8'd21 || last_o5 !== 8'd21) begin
      errors++;
      $display("FAIL chg_out got %b/%0d/%0d want 1/21/21", last_v16, last_o16, last_o5);
    end
  endtask

  task automatic test_wrap5();
    step(8'd0, 1'b0, 5, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(8'(100 + i), 1'b1, 5, 1'b0);
      if (i >= 6) begin
        checks++;
        if (last_v5 !== 1'b1 || last_o5 !== 8'(95 + i)) begin
          errors++;
          $display("FAIL wrap5 beat %0d got %b/%0d want 1/%0d", i, last_v5, last_o5, 95 + i);
        end
      end
    end
    checks++;
    if (b5.fill !== 3'd5) begin
      errors++;
      $display("FAIL wrap5_fill_sat got %0d want 5", b5.fill);
    end
  endtask

  task automatic test_clamp_flush();
    int nvalid;
    step(8'd0, 1'b0, 31, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(8'(200 + i), 1'b1, 31, 1'b0);
      if (i == 15 || i == 16) begin
        checks++;
        if (last_v16 !== (i == 16) || (i == 16 && last_o16 !== 8'd200)) begin
          errors++;
          $display("FAIL clamp16 beat %0d got %b/%0d want %b/200", i, last_v16, last_o16, i == 16);
        end
      end
    end
    step(8'd50, 1'b1, 31, 1'b1);
    checks++;
    if (b16.fill !== 5'd0) begin
      errors++;
      $display("FAIL flush_with_valid got fill %0d want 0", b16.fill);
    end
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'(60 + i), 1'b1, 31, 1'b0);
      if (last_v16 === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL flush_refill got %0d valid beats want 0", nvalid);
    end
    step(8'd90, 1'b1, 31, 1'b0);
    checks++;
    if (last_v16 !== 1'b1 || last_o16 !== 8'd60) begin
      errors++;
      $display("FAIL flush_resume got %b/%0d want 1/60", last_v16, last_o16);
    end
    // Async reset in the middle of a valid beat.
    b16.in = 8'd91;  b5.in = 8'd91;
    b16.in_valid = 1'b1;  b5.in_valid = 1'b1;
    #1;
    checks++;
    if (b16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_valid got %b want 1", b16.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b16.out_valid !== 1'b0 || b5.out_valid !== 1'b0 || b16.fill !== 5'd0 || b5.fill !== 3'd0) begin
      errors++;
      $display("FAIL async_rst got valid %b/%b fill %0d/%0d want 0/0 0/0",
               b16.out_valid, b5.out_valid, b16.fill, b5.fill);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    b16.in_valid = 1'b0;  b5.in_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) step(8'(120 + i), 1'b1, 31, 1'b0);
  endtask

  task automatic test_back_to_back();
    int dlys[7] = '{0, 1, 2, 5, 9, 16, 31};
    int dly;
    dly = 4;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) dly = dlys[$urandom_range(0, 6)];
      step(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), dly,
           ($urandom_range(0, 59) == 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    b16.in = '0;  b16.in_valid = 1'b0;  b16.delay = '0;  b16.flush = 1'b0;
    b5.in  = '0;  b5.in_valid  = 1'b0;  b5.delay  = '0;  b5.flush  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_delay3_ramp();
    test_bypass();
    test_stall();
    test_delay_change();
    test_wrap5();
    test_clamp_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
